// File: rtl/l1_req_sequencer_pkg.sv
// l1_req_sequencer_pkg
// Shared definitions for the L1 request sequencer: cache geometry constants,
// command / MESI / FSM / source encodings, and the command legality rule.
package l1_req_sequencer_pkg;

    // Cache geometry: 16K sets of 64 B lines behind a 32-bit address.
    localparam int L1_NUM_SETS    = 16384;
    localparam int L1_LINE_BYTES  = 64;
    localparam int L1_ADDR_BITS   = 32;
    localparam int L1_INDEX_BITS  = $clog2(L1_NUM_SETS);
    localparam int L1_OFFSET_BITS = $clog2(L1_LINE_BYTES);
    localparam int L1_TAG_BITS    = L1_ADDR_BITS - L1_INDEX_BITS - L1_OFFSET_BITS;

    typedef enum logic [3:0] {
        CMD_READ       = 4'd0,
        CMD_WRITE      = 4'd1,
        CMD_I_FETCH    = 4'd2,
        CMD_L2_INVAL   = 4'd3,
        CMD_L2_DATA_RQ = 4'd4,
        CMD_CLR        = 4'd8,
        CMD_PRINT      = 4'd9
    } cmd_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_RSP,
        ST_UPDATE,
        ST_CLEAR
    } state_e;

    typedef enum logic [1:0] {
        SRC_SNOOP = 2'd0,
        SRC_DATA  = 2'd1,
        SRC_FETCH = 2'd2
    } src_e;

    // Which commands each port may legally issue. Fetch has no command field.
    function automatic logic cmd_legal(input src_e src, input logic [3:0] cmd);
        case (src)
            SRC_SNOOP: return (cmd == CMD_L2_INVAL) || (cmd == CMD_L2_DATA_RQ);
            SRC_DATA:  return (cmd == CMD_READ) || (cmd == CMD_WRITE) ||
                              (cmd == CMD_CLR)  || (cmd == CMD_PRINT);
            SRC_FETCH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/l1_req_sequencer_if.sv
// l1_req_sequencer_if
// Bundles the three request ports, the tag-array port and the completion
// port of the sequencer.
//   slave  : sequencer view (accepts requests, drives the tag array)
//   master : environment view (issues requests, acts as the tag array)
interface l1_req_sequencer_if #(
    parameter int ADDRESS_BITS = l1_req_sequencer_pkg::L1_ADDR_BITS,
    parameter int INDEX_BITS   = l1_req_sequencer_pkg::L1_INDEX_BITS,
    parameter int OFFSET_BITS  = l1_req_sequencer_pkg::L1_OFFSET_BITS,
    parameter int TAG_BITS     = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS
);
    // snoop port
    logic                    s_valid;
    logic                    s_ready;
    logic [3:0]              s_cmd;
    logic [ADDRESS_BITS-1:0] s_addr;
    // data-side port
    logic                    d_valid;
    logic                    d_ready;
    logic [3:0]              d_cmd;
    logic [ADDRESS_BITS-1:0] d_addr;
    // instruction-fetch port
    logic                    i_valid;
    logic                    i_ready;
    logic [ADDRESS_BITS-1:0] i_addr;
    // tag-array port
    logic                    ta_rd_en;
    logic                    ta_icache;
    logic [INDEX_BITS-1:0]   ta_index;
    logic [TAG_BITS-1:0]     ta_tag;
    logic                    ta_rsp_valid;
    logic                    ta_hit;
    logic [2:0]              ta_way;
    logic [1:0]              ta_mesi;
    logic                    ta_wr_en;
    logic [2:0]              ta_wr_way;
    logic [1:0]              ta_wr_mesi;
    logic                    ta_clr_en;
    // completion
    logic                    done_valid;
    logic [1:0]              done_src;
    logic                    done_hit;
    logic                    done_err;

    modport slave (
        input  s_valid, s_cmd, s_addr,
        input  d_valid, d_cmd, d_addr,
        input  i_valid, i_addr,
        input  ta_rsp_valid, ta_hit, ta_way, ta_mesi,
        output s_ready, d_ready, i_ready,
        output ta_rd_en, ta_icache, ta_index, ta_tag,
        output ta_wr_en, ta_wr_way, ta_wr_mesi, ta_clr_en,
        output done_valid, done_src, done_hit, done_err
    );

    modport master (
        output s_valid, s_cmd, s_addr,
        output d_valid, d_cmd, d_addr,
        output i_valid, i_addr,
        output ta_rsp_valid, ta_hit, ta_way, ta_mesi,
        input  s_ready, d_ready, i_ready,
        input  ta_rd_en, ta_icache, ta_index, ta_tag,
        input  ta_wr_en, ta_wr_way, ta_wr_mesi, ta_clr_en,
        input  done_valid, done_src, done_hit, done_err
    );
endinterface

// File: rtl/l1_req_sequencer_req_prio_arb.sv
// req_prio_arb
// Combinational grant: snoop has fixed top priority; data vs fetch is settled
// by a registered round-robin pointer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   en                     : grants allowed this cycle
//   s_req, d_req, i_req    : requests
//   s_gnt, d_gnt, i_gnt    : one-hot (or zero) grants
module req_prio_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s_req,
    input  logic d_req,
    input  logic i_req,
    output logic s_gnt,
    output logic d_gnt,
    output logic i_gnt
);
    // 0: data wins a data/fetch tie, 1: fetch wins.
    logic favor_fetch_reg;

    always_comb begin
        s_gnt = en && s_req;
        d_gnt = en && !s_req && d_req && (!favor_fetch_reg || !i_req);
        i_gnt = en && !s_req && i_req && ( favor_fetch_reg || !d_req);
    end

    // After serving one side the other side is favoured, so a waiting port
    // never loses more than one operation to its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favor_fetch_reg <= 1'b0;
        end else if (d_gnt) begin
            favor_fetch_reg <= 1'b1;
        end else if (i_gnt) begin
            favor_fetch_reg <= 1'b0;
        end
    end
endmodule

// File: rtl/l1_req_sequencer.sv
// l1_req_sequencer
// Front-end controller for the split L1 tag/state arrays. Accepts one
// operation at a time from the snoop, data and fetch ports, runs it through
// lookup / response / state update against the shared tag-array port, and
// sequences the whole-array CLR sweep (data array, then instruction array).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request ports, tag-array port and completion pulse
module l1_req_sequencer
    import l1_req_sequencer_pkg::*;
#(
    parameter int ADDRESS_BITS = L1_ADDR_BITS,
    parameter int INDEX_BITS   = L1_INDEX_BITS,
    parameter int OFFSET_BITS  = L1_OFFSET_BITS,
    parameter int TAG_BITS     = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS,
    parameter int NUM_SETS     = 2 ** INDEX_BITS
) (
    input  logic clk,
    input  logic rst_n,
    l1_req_sequencer_if.slave bus
);
    // Sweep counter: low bits are the set index, top bit selects the array.
    localparam int                CLR_BITS = $clog2(NUM_SETS) + 1;
    localparam logic [CLR_BITS-1:0] CLR_LAST = CLR_BITS'(2 * NUM_SETS - 1);

    state_e                  state_reg, state_next;
    src_e                    src_reg;
    cmd_e                    cmd_reg;
    logic                    err_reg;
    logic [INDEX_BITS-1:0]   index_reg;
    logic [TAG_BITS-1:0]     tag_reg;
    logic                    hit_reg;
    logic [2:0]              way_reg;
    mesi_e                   mesi_reg;
    logic [CLR_BITS-1:0]     clr_cnt_reg;

    logic                    arb_en;
    logic                    s_gnt, d_gnt, i_gnt, grant_any;
    src_e                    grant_src;
    logic [3:0]              grant_cmd;
    logic [ADDRESS_BITS-1:0] grant_addr;
    logic                    grant_legal;
    logic                    unused_offset;

    logic                    rd_en, icache, wr_en, clr_en;
    logic [2:0]              wr_way;
    mesi_e                   wr_mesi;
    logic                    done_valid, done_hit, done_err;
    src_e                    done_src;

    // Readies are forced low while reset is held so every output reads 0.
    assign arb_en = rst_n && (state_reg == ST_IDLE);

    req_prio_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .s_req (bus.s_valid),
        .d_req (bus.d_valid),
        .i_req (bus.i_valid),
        .s_gnt (s_gnt),
        .d_gnt (d_gnt),
        .i_gnt (i_gnt)
    );

    assign bus.s_ready = s_gnt;
    assign bus.d_ready = d_gnt;
    assign bus.i_ready = i_gnt;
    assign grant_any   = s_gnt || d_gnt || i_gnt;

    always_comb begin
        grant_src  = SRC_FETCH;
        grant_cmd  = CMD_I_FETCH;
        grant_addr = bus.i_addr;
        if (s_gnt) begin
            grant_src  = SRC_SNOOP;
            grant_cmd  = bus.s_cmd;
            grant_addr = bus.s_addr;
        end else if (d_gnt) begin
            grant_src  = SRC_DATA;
            grant_cmd  = bus.d_cmd;
            grant_addr = bus.d_addr;
        end
    end

    assign grant_legal   = cmd_legal(grant_src, grant_cmd);
    // Line-offset bits never reach the tag array.
    assign unused_offset = ^grant_addr[OFFSET_BITS-1:0];

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        icache     = 1'b0;
        wr_en      = 1'b0;
        wr_way     = 3'd0;
        wr_mesi    = MESI_I;
        clr_en     = 1'b0;
        done_valid = 1'b0;
        done_src   = SRC_SNOOP;
        done_hit   = 1'b0;
        done_err   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    // PRINT and illegal commands report completion without
                    // touching the array.
                    if (!grant_legal || grant_cmd == CMD_PRINT) begin
                        state_next = ST_UPDATE;
                    end else if (grant_cmd == CMD_CLR) begin
                        state_next = ST_CLEAR;
                    end else begin
                        state_next = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                rd_en      = 1'b1;
                icache     = (src_reg == SRC_FETCH);
                state_next = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                icache = (src_reg == SRC_FETCH);
                if (bus.ta_rsp_valid) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                icache     = (src_reg == SRC_FETCH);
                done_valid = 1'b1;
                done_src   = src_reg;
                done_hit   = hit_reg;
                done_err   = err_reg;
                wr_way     = way_reg;
                if (!err_reg) begin
                    case (cmd_reg)
                        CMD_READ: begin
                            wr_en   = 1'b1;
                            wr_mesi = hit_reg ? mesi_reg : MESI_E;
                        end
                        CMD_WRITE: begin
                            wr_en   = 1'b1;
                            wr_mesi = MESI_M;
                        end
                        CMD_I_FETCH: begin
                            wr_en   = 1'b1;
                            wr_mesi = hit_reg ? mesi_reg : MESI_S;
                        end
                        CMD_L2_INVAL: begin
                            wr_en   = hit_reg;
                            wr_mesi = MESI_I;
                        end
                        CMD_L2_DATA_RQ: begin
                            // Downgrade owned lines only; S stays S untouched.
                            wr_en   = hit_reg && (mesi_reg == MESI_M || mesi_reg == MESI_E);
                            wr_mesi = MESI_S;
                        end
                        default: begin
                            wr_en = 1'b0;
                        end
                    endcase
                end
                if (!wr_en) begin
                    wr_way = 3'd0;
                end
                state_next = ST_IDLE;
            end
            ST_CLEAR: begin
                clr_en = 1'b1;
                icache = clr_cnt_reg[CLR_BITS-1];
                if (clr_cnt_reg == CLR_LAST) begin
                    done_valid = 1'b1;
                    done_src   = SRC_DATA;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            src_reg     <= SRC_SNOOP;
            cmd_reg     <= CMD_READ;
            err_reg     <= 1'b0;
            index_reg   <= '0;
            tag_reg     <= '0;
            hit_reg     <= 1'b0;
            way_reg     <= 3'd0;
            mesi_reg    <= MESI_I;
            clr_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && grant_any) begin
                src_reg   <= grant_src;
                cmd_reg   <= cmd_e'(grant_cmd);
                err_reg   <= !grant_legal;
                index_reg <= grant_addr[OFFSET_BITS +: INDEX_BITS];
                tag_reg   <= grant_addr[ADDRESS_BITS-1 -: TAG_BITS];
                hit_reg   <= 1'b0;
                way_reg   <= 3'd0;
                mesi_reg  <= MESI_I;
            end
            if (state_reg == ST_WAIT_RSP && bus.ta_rsp_valid) begin
                hit_reg  <= bus.ta_hit;
                way_reg  <= bus.ta_way;
                mesi_reg <= mesi_e'(bus.ta_mesi);
            end
            // Wraps back to 0 on the final sweep cycle.
            if (state_reg == ST_CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + CLR_BITS'(1);
            end
        end
    end

    assign bus.ta_rd_en   = rd_en;
    assign bus.ta_icache  = icache;
    assign bus.ta_index   = (state_reg == ST_CLEAR) ? clr_cnt_reg[INDEX_BITS-1:0] : index_reg;
    assign bus.ta_tag     = tag_reg;
    assign bus.ta_wr_en   = wr_en;
    assign bus.ta_wr_way  = wr_way;
    assign bus.ta_wr_mesi = wr_mesi;
    assign bus.ta_clr_en  = clr_en;
    assign bus.done_valid = done_valid;
    assign bus.done_src   = done_src;
    assign bus.done_hit   = done_hit;
    assign bus.done_err   = done_err;
endmodule

// File: tb/tb_l1_req_sequencer.sv
// tb_l1_req_sequencer
// Self-checking bench for l1_req_sequencer: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_l1_req_sequencer;
    import l1_req_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passes = 0;

    l1_req_sequencer_if bus ();

    l1_req_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_valid = 0; bus.s_cmd = 0; bus.s_addr = 0;
        bus.d_valid = 0; bus.d_cmd = 0; bus.d_addr = 0;
        bus.i_valid = 0; bus.i_addr = 0;
        bus.ta_rsp_valid = 0; bus.ta_hit = 0; bus.ta_way = 0; bus.ta_mesi = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    // Samplers (no checking)
    function automatic logic [2:0] rdy();
        return {bus.s_ready, bus.d_ready, bus.i_ready};
    endfunction
    function automatic logic [42:0] all_out();
        return {rdy(), bus.ta_rd_en, bus.ta_icache, bus.ta_index, bus.ta_tag,
                bus.ta_wr_en, bus.ta_wr_way, bus.ta_wr_mesi, bus.ta_clr_en,
                bus.done_valid, bus.done_src, bus.done_hit, bus.done_err};
    endfunction
    function automatic logic [27:0] lk();
        return {bus.ta_rd_en, bus.ta_icache, bus.ta_index, bus.ta_tag};
    endfunction
    function automatic logic [7:0] upd();
        return {bus.done_valid, bus.done_src, bus.done_hit, bus.done_err,
                bus.ta_wr_en, bus.ta_rd_en, bus.ta_clr_en};
    endfunction

    // Reference model: command legality and MESI outcome tables.
    function automatic logic legal(input int src, input logic [3:0] cmd);
        if (src == 0) return (cmd == 3) || (cmd == 4);
        if (src == 1) return (cmd == 0) || (cmd == 1) || (cmd == 8) || (cmd == 9);
        return 1'b1;
    endfunction
    // {write, way, new mesi}
    function automatic logic [5:0] exp_write(input logic [3:0] cmd, input logic hit,
                                             input logic [2:0] way, input logic [1:0] mesi);
        case (cmd)
            4'd0: return {1'b1, way, hit ? mesi : 2'd2};
            4'd1: return {1'b1, way, 2'd3};
            4'd2: return {1'b1, way, hit ? mesi : 2'd1};
            4'd3: return hit ? {1'b1, way, 2'd0} : 6'd0;
            4'd4: return (hit && mesi >= 2'd2) ? {1'b1, way, 2'd1} : 6'd0;
            default: return 6'd0;
        endcase
    endfunction

    task automatic test_reset();
        idle_inputs();
        bus.s_valid = 1; bus.d_valid = 1; bus.i_valid = 1;
        rst_n = 0;
        step();
        step();
        checks++;
        if (all_out() !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out());
        else passes++;
        idle_inputs();
        rst_n = 1;
        step();
        checks++;
        if (all_out() !== '0) $display("FAIL post_reset_idle: got %h expected 0", all_out());
        else passes++;
    endtask

    task automatic test_read_miss();
        bus.d_valid = 1; bus.d_cmd = 4'd0; bus.d_addr = 32'h0000_1040;
        #1;
        checks++;
        if (rdy() !== 3'b010) $display("FAIL read_miss_ready: got %b expected 010", rdy());
        else passes++;
        step();
        bus.d_valid = 0;
        checks++;
        if (lk() !== {1'b1, 1'b0, 14'h0041, 12'h000}) $display("FAIL read_miss_lookup: got %h expected %h", lk(), {1'b1, 1'b0, 14'h0041, 12'h000});
        else passes++;
        step();
        checks++;
        if (upd() !== 8'd0) $display("FAIL read_miss_wait: got %b expected 00000000", upd());
        else passes++;
        bus.ta_rsp_valid = 1; bus.ta_hit = 0; bus.ta_way = 3'd5; bus.ta_mesi = 2'd0;
        step();
        bus.ta_rsp_valid = 0;
        checks++;
        if ({upd(), bus.ta_wr_way, bus.ta_wr_mesi, bus.ta_index} !== {8'b1_01_0_0_1_0_0, 3'd5, 2'd2, 14'h0041})
            $display("FAIL read_miss_update: got %b/%0d/%0d/%h expected 10100100/5/2/0041", upd(), bus.ta_wr_way, bus.ta_wr_mesi, bus.ta_index);
        else passes++;
        step();
        checks++;
        if (upd() !== 8'd0) $display("FAIL read_miss_idle: got %b expected 00000000", upd());
        else passes++;
    endtask

    task automatic test_snoop_priority();
        logic [31:0] sa, da;
        sa = 32'h00AB_C0C0;
        da = 32'h1234_5678;
        bus.s_valid = 1; bus.s_cmd = 4'd3; bus.s_addr = sa;
        bus.d_valid = 1; bus.d_cmd = 4'd0; bus.d_addr = da;
        #1;
        checks++;
        if (rdy() !== 3'b100) $display("FAIL snoop_prio_ready: got %b expected 100", rdy());
        else passes++;
        step();
        bus.s_valid = 0;
        checks++;
        if ({rdy(), lk()} !== {3'b000, 1'b1, 1'b0, sa[19:6], sa[31:20]}) $display("FAIL snoop_prio_lookup: got %h expected %h", {rdy(), lk()}, {3'b000, 1'b1, 1'b0, sa[19:6], sa[31:20]});
        else passes++;
        step();
        bus.ta_rsp_valid = 1; bus.ta_hit = 1; bus.ta_way = 3'd3; bus.ta_mesi = 2'd3;
        step();
        bus.ta_rsp_valid = 0;
        checks++;
        if ({rdy(), upd(), bus.ta_wr_way, bus.ta_wr_mesi} !== {3'b000, 8'b1_00_1_0_1_0_0, 3'd3, 2'd0})
            $display("FAIL snoop_inval_update: got %b/%b/%0d/%0d expected 000/10010100/3/0", rdy(), upd(), bus.ta_wr_way, bus.ta_wr_mesi);
        else passes++;
        step();
        checks++;
        if (rdy() !== 3'b010) $display("FAIL snoop_then_data_ready: got %b expected 010", rdy());
        else passes++;
        step();
        bus.d_valid = 0;
        checks++;
        if (lk() !== {1'b1, 1'b0, da[19:6], da[31:20]}) $display("FAIL data_after_snoop_lookup: got %h expected %h", lk(), {1'b1, 1'b0, da[19:6], da[31:20]});
        else passes++;
        step();
        bus.ta_rsp_valid = 1; bus.ta_hit = 1; bus.ta_way = 3'd1; bus.ta_mesi = 2'd1;
        step();
        bus.ta_rsp_valid = 0;
        checks++;
        if ({upd(), bus.ta_wr_way, bus.ta_wr_mesi} !== {8'b1_01_1_0_1_0_0, 3'd1, 2'd1})
            $display("FAIL data_read_hit_update: got %b/%0d/%0d expected 10110100/1/1", upd(), bus.ta_wr_way, bus.ta_wr_mesi);
        else passes++;
        step();
    endtask

    task automatic test_illegal();
        // {port (0 snoop / 1 data), cmd, expected err}
        int       port_t[4] = '{0, 1, 1, 0};
        logic [3:0] cmd_t[4] = '{4'd0, 4'd9, 4'd5, 4'd8};
        logic     err_t[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int n = 0; n < 4; n++) begin
            if (port_t[n] == 0) begin
                bus.s_valid = 1; bus.s_cmd = cmd_t[n]; bus.s_addr = $urandom();
            end else begin
                bus.d_valid = 1; bus.d_cmd = cmd_t[n]; bus.d_addr = $urandom();
            end
            #1;
            checks++;
            if (rdy() !== ((port_t[n] == 0) ? 3'b100 : 3'b010)) $display("FAIL nolookup_ready[%0d]: got %b", n, rdy());
            else passes++;
            step();
            bus.s_valid = 0; bus.d_valid = 0;
            checks++;
            if (upd() !== {1'b1, 2'(port_t[n]), 1'b0, err_t[n], 3'b000})
                $display("FAIL nolookup_done[%0d] cmd %0d: got %b expected %b", n, cmd_t[n], upd(), {1'b1, 2'(port_t[n]), 1'b0, err_t[n], 3'b000});
            else passes++;
            step();
            checks++;
            if (upd() !== 8'd0) $display("FAIL nolookup_idle[%0d]: got %b expected 00000000", n, upd());
            else passes++;
        end
    endtask

    task automatic test_rr_alternate();
        apply_reset();
        bus.d_valid = 1; bus.d_cmd = 4'd0; bus.i_valid = 1;
        for (int n = 0; n < 4; n++) begin
            bus.d_addr = $urandom(); bus.i_addr = $urandom();
            #1;
            checks++;
            if (rdy() !== ((n % 2 == 0) ? 3'b010 : 3'b001)) $display("FAIL rr_grant[%0d]: got %b expected %b", n, rdy(), (n % 2 == 0) ? 3'b010 : 3'b001);
            else passes++;
            step();
            checks++;
            if ({rdy(), bus.ta_rd_en, bus.ta_icache} !== {3'b000, 1'b1, (n % 2 == 1)}) $display("FAIL rr_lookup[%0d]: got %b", n, {rdy(), bus.ta_rd_en, bus.ta_icache});
            else passes++;
            step();
            bus.ta_rsp_valid = 1; bus.ta_hit = 0; bus.ta_way = 3'(n);
            checks++;
            if (rdy() !== 3'b000) $display("FAIL rr_wait_ready[%0d]: got %b expected 000", n, rdy());
            else passes++;
            step();
            bus.ta_rsp_valid = 0;
            checks++;
            if ({rdy(), bus.done_valid, bus.done_src} !== {3'b000, 1'b1, (n % 2 == 0) ? 2'd1 : 2'd2}) $display("FAIL rr_done[%0d]: got %b", n, {rdy(), bus.done_valid, bus.done_src});
            else passes++;
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        logic        favor_fetch;
        int          src, k;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        hit;
        logic [2:0]  way;
        logic [1:0]  mesi;
        logic [5:0]  w;
        logic [2:0]  exp_rdy;
        apply_reset();
        favor_fetch = 0;
        for (int n = 0; n < 200; n++) begin
            if (!bus.s_valid && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1; bus.s_addr = $urandom();
                k = $urandom_range(0, 7);
                if (k < 3) bus.s_cmd = 4'd3;
                else if (k < 6) bus.s_cmd = 4'd4;
                else begin
                    do cmd = 4'($urandom_range(0, 15)); while (cmd == 3 || cmd == 4);
                    bus.s_cmd = cmd;
                end
            end
            if (!bus.d_valid && $urandom_range(0, 1) == 0) begin
                bus.d_valid = 1; bus.d_addr = $urandom();
                k = $urandom_range(0, 7);
                if (k < 3) bus.d_cmd = 4'd0;
                else if (k < 6) bus.d_cmd = 4'd1;
                else if (k == 6) bus.d_cmd = 4'd9;
                else begin
                    do cmd = 4'($urandom_range(0, 15)); while (cmd == 0 || cmd == 1 || cmd == 8 || cmd == 9);
                    bus.d_cmd = cmd;
                end
            end
            if (!bus.i_valid && $urandom_range(0, 1) == 0) begin
                bus.i_valid = 1; bus.i_addr = $urandom();
            end
            #1;
            src = -1;
            if (bus.s_valid) src = 0;
            else if (bus.d_valid && bus.i_valid) src = favor_fetch ? 2 : 1;
            else if (bus.d_valid) src = 1;
            else if (bus.i_valid) src = 2;
            exp_rdy = (src == 0) ? 3'b100 : (src == 1) ? 3'b010 : (src == 2) ? 3'b001 : 3'b000;
            checks++;
            if (rdy() !== exp_rdy) $display("FAIL rand_grant[%0d]: got %b expected %b", n, rdy(), exp_rdy);
            else passes++;
            if (src < 0) begin
                step();
                continue;
            end
            if (src == 0) begin cmd = bus.s_cmd; addr = bus.s_addr; end
            else if (src == 1) begin cmd = bus.d_cmd; addr = bus.d_addr; favor_fetch = 1; end
            else begin cmd = 4'd2; addr = bus.i_addr; favor_fetch = 0; end
            step();
            if (src == 0) bus.s_valid = 0;
            else if (src == 1) bus.d_valid = 0;
            else bus.i_valid = 0;
            if (!legal(src, cmd) || cmd == 4'd9) begin
                checks++;
                if ({rdy(), upd()} !== {3'b000, 1'b1, 2'(src), 1'b0, !legal(src, cmd), 3'b000})
                    $display("FAIL rand_nolookup[%0d] src %0d cmd %0d: got %b expected %b", n, src, cmd, {rdy(), upd()}, {3'b000, 1'b1, 2'(src), 1'b0, !legal(src, cmd), 3'b000});
                else passes++;
                step();
                continue;
            end
            checks++;
            if ({rdy(), lk()} !== {3'b000, 1'b1, (src == 2), addr[19:6], addr[31:20]})
                $display("FAIL rand_lookup[%0d]: got %h expected %h", n, {rdy(), lk()}, {3'b000, 1'b1, (src == 2), addr[19:6], addr[31:20]});
            else passes++;
            k = $urandom_range(1, 3);
            hit = 1'($urandom_range(0, 1)); way = 3'($urandom_range(0, 7)); mesi = 2'($urandom_range(0, 3));
            for (int j = 1; j <= k; j++) begin
                step();
                checks++;
                if ({rdy(), upd()} !== 11'd0) $display("FAIL rand_wait[%0d] cycle %0d: got %b expected 0", n, j, {rdy(), upd()});
                else passes++;
                if (j == k) begin
                    bus.ta_rsp_valid = 1; bus.ta_hit = hit; bus.ta_way = way; bus.ta_mesi = mesi;
                end
            end
            step();
            bus.ta_rsp_valid = 0;
            w = exp_write(cmd, hit, way, mesi);
            checks++;
            if ({rdy(), upd(), lk()} !== {3'b000, 1'b1, 2'(src), hit, 1'b0, w[5], 2'b00, 1'b0, (src == 2), addr[19:6], addr[31:20]})
                $display("FAIL rand_update[%0d] src %0d cmd %0d hit %0b mesi %0d: got %b/%h expected wr %0b", n, src, cmd, hit, mesi, upd(), lk(), w[5]);
            else passes++;
            if (w[5]) begin
                checks++;
                if ({bus.ta_wr_way, bus.ta_wr_mesi} !== w[4:0]) $display("FAIL rand_write[%0d] cmd %0d: got way %0d mesi %0d expected way %0d mesi %0d", n, cmd, bus.ta_wr_way, bus.ta_wr_mesi, w[4:2], w[1:0]);
                else passes++;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        bus.d_valid = 1; bus.d_cmd = 4'd1; bus.d_addr = 32'hFFFF_FFC0;
        step();
        bus.d_valid = 0;
        step();
        rst_n = 0;
        #1;
        checks++;
        if (all_out() !== '0) $display("FAIL midop_reset_outputs: got %h expected 0", all_out());
        else passes++;
        step();
        rst_n = 1;
        bus.ta_rsp_valid = 1; bus.ta_hit = 1; bus.ta_way = 3'd2; bus.ta_mesi = 2'd3;
        step();
        bus.ta_rsp_valid = 0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done_valid || bus.ta_wr_en || bus.ta_rd_en) done_seen++;
            step();
        end
        checks++;
        if (done_seen !== 0) $display("FAIL midop_late_rsp: got %0d activity cycles expected 0", done_seen);
        else passes++;
    endtask

    task automatic test_clear();
        int bad, dones, done_at;
        logic [1:0] done_src_last;
        bad = 0; dones = 0; done_at = -1; done_src_last = 2'd3;
        bus.d_valid = 1; bus.d_cmd = 4'd8; bus.d_addr = $urandom();
        #1;
        checks++;
        if (rdy() !== 3'b010) $display("FAIL clr_ready: got %b expected 010", rdy());
        else passes++;
        step();
        bus.d_valid = 0;
        for (int c = 0; c < 32768; c++) begin
            if (c != 0) step();
            if (bus.ta_clr_en !== 1'b1 || bus.ta_index !== 14'(c % 16384) ||
                bus.ta_icache !== (c >= 16384) || bus.ta_rd_en !== 1'b0 || bus.ta_wr_en !== 1'b0) begin
                if (bad == 0) $display("FAIL clr_cycle %0d: got clr %0b index %h icache %0b expected 1 %h %0b", c, bus.ta_clr_en, bus.ta_index, bus.ta_icache, 14'(c % 16384), (c >= 16384));
                bad++;
            end
            if (bus.done_valid) begin
                dones++;
                done_at = c;
                done_src_last = bus.done_src;
            end
        end
        checks++;
        if (bad !== 0) $display("FAIL clr_sweep: got %0d bad cycles expected 0", bad);
        else passes++;
        checks++;
        if ({dones, done_at} !== {32'd1, 32'd32767}) $display("FAIL clr_done: got %0d pulses at %0d expected 1 at 32767", dones, done_at);
        else passes++;
        checks++;
        if (done_src_last !== 2'd1) $display("FAIL clr_done_src: got %0d expected 1", done_src_last);
        else passes++;
        step();
        checks++;
        if ({bus.ta_clr_en, bus.done_valid} !== 2'b00) $display("FAIL clr_exit: got %b expected 00", {bus.ta_clr_en, bus.done_valid});
        else passes++;
    endtask

    initial begin
        idle_inputs();
        #3;
        test_reset();
        test_read_miss();
        test_snoop_priority();
        test_illegal();
        test_rr_alternate();
        test_random();
        test_reset_mid_op();
        test_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
